// File: rtl/uart_pkg.sv
// Shared UART transmit types: FSM state encoding and the frame parity helper.
package uart_pkg;

   localparam int UART_MAX_DATA_BITS = 9;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

   // Payload is zero-extended to the widest frame, so the extra zeros do not disturb the XOR.
   function automatic logic uart_parity(input logic [UART_MAX_DATA_BITS-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit word queue: DEPTH entries (power of two), registered count/full/empty.
// Latency: a pushed word is visible at pop_dat one cycle after the push edge.
// Backpressure: a push while full is dropped even if a pop happens in the same cycle.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_dat,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign pop_dat = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Pointers wrap for free because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push_ok);
      rd_ptr_d = rd_ptr_q + PW'(pop_ok);
      count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_dat;
      end
   end

endmodule

// File: rtl/uart_tx_param.sv
// Queued UART transmitter, DATA_BITS/STOP_BITS configurable; parity bit only with UART_TX_PARITY_EN.
// Latency: push into an empty queue with the FSM idle drives the start bit two edges later.
// Backpressure: tx_ready is registered and drops when the queue holds FIFO_DEPTH words.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst_,
   input  logic                            tx_valid,
   input  logic [DATA_BITS-1:0]            tx_data,
   output logic                            tx_ready,
   input  logic                            parity_odd,
   output logic                            tx_serial,
   output logic                            tx_busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

   localparam int DIVISOR = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam int CW      = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIVISOR - 1);
   localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

   if (DIVISOR < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("uart_tx_param: illegal parameter combination");
   end

   uart_tx_state_t         state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [3:0]             bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   tx_serial_q, tx_serial_d;
   logic                   tx_ready_q, tx_ready_d;
   logic                   tick, load;
   logic                   push_acc, fifo_pop, fifo_full, fifo_empty;
   logic [DATA_BITS-1:0]   fifo_dat;
   logic [CW-1:0]          fifo_cnt, cnt_nxt;

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_     (rst_),
      .push     (push_acc),
      .push_dat (tx_data),
      .pop      (fifo_pop),
      .pop_dat  (fifo_dat),
      .count    (fifo_cnt),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign push_acc   = tx_valid && tx_ready_q;
   assign tick       = (cnt_q == CNT_LAST);
   assign tx_serial  = tx_serial_q;
   assign tx_ready   = tx_ready_q;
   assign tx_busy    = (state_q != IDLE);
   assign fifo_count = fifo_cnt;

   // Ready is registered from the count the queue will hold after this edge.
   always_comb begin
      cnt_nxt    = fifo_cnt + CW'(push_acc && !fifo_full) - CW'(fifo_pop);
      tx_ready_d = (cnt_nxt < CW'(FIFO_DEPTH));
   end

`ifdef UART_TX_PARITY_EN
   logic par_bit_q, par_bit_d;
`else
   logic unused_parity_odd;
   assign unused_parity_odd = parity_odd;
`endif

   // The line is registered from the current state, so it trails the FSM by one cycle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
      bit_d       = bit_q;
      shift_d     = shift_q;
      tx_serial_d = 1'b1;
      load        = 1'b0;
      fifo_pop    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit_d   = par_bit_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            load  = !fifo_empty;
         end
         START: begin
            tx_serial_d = 1'b0;
            if (tick) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            tx_serial_d = shift_q[0];
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bit_q == DATA_LAST) begin
                  bit_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            tx_serial_d = par_bit_q;
            if (tick) begin
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (bit_q == STOP_LAST) begin
                  state_d = IDLE;
                  load    = !fifo_empty;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         fifo_pop = 1'b1;
         shift_d  = fifo_dat;
         state_d  = START;
         cnt_d    = '0;
         bit_d    = '0;
`ifdef UART_TX_PARITY_EN
         par_bit_d = uart_parity(9'(fifo_dat), parity_odd);
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         tx_serial_q <= 1'b1;
         tx_ready_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_bit_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         tx_serial_q <= tx_serial_d;
         tx_ready_q  <= tx_ready_d;
`ifdef UART_TX_PARITY_EN
         par_bit_q   <= par_bit_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three instances (8N1, 8N2, 5N1) at DIVISOR=10, frame scoreboard on the serial line.
module tb_uart_tx_param;

   localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] rst_nv;
   logic [2:0] vld;
   logic [8:0] drv_dat;
   logic       par_odd;
   logic       rdy0, rdy1, rdy2, ser0, ser1, ser2, busy0, busy1, busy2;
   logic [2:0] cnt0, cnt1, cnt2;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] bits;
      int          nper;
   } frame_t;

   frame_t sb[$];
   int     mon_sel   = 0;
   bit     gap_mode  = 1'b0;
   bit     have_prev = 1'b0;
   int     prev_end  = 0;
   int     frames_ok = 0;

   uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
      .clk(clk), .rst_(rst_nv[0]), .tx_valid(vld[0]), .tx_data(drv_dat[7:0]), .tx_ready(rdy0),
      .parity_odd(par_odd), .tx_serial(ser0), .tx_busy(busy0), .fifo_count(cnt0));

   uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
      .clk(clk), .rst_(rst_nv[1]), .tx_valid(vld[1]), .tx_data(drv_dat[7:0]), .tx_ready(rdy1),
      .parity_odd(par_odd), .tx_serial(ser1), .tx_busy(busy1), .fifo_count(cnt1));

   uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(5), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
      .clk(clk), .rst_(rst_nv[2]), .tx_valid(vld[2]), .tx_data(drv_dat[4:0]), .tx_ready(rdy2),
      .parity_odd(par_odd), .tx_serial(ser2), .tx_busy(busy2), .fifo_count(cnt2));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic cur_line(input int s);
      case (s)
         0:       return ser0;
         1:       return ser1;
         default: return ser2;
      endcase
   endfunction

   function automatic logic cur_busy(input int s);
      case (s)
         0:       return busy0;
         1:       return busy1;
         default: return busy2;
      endcase
   endfunction

   function automatic logic cur_ready(input int s);
      case (s)
         0:       return rdy0;
         1:       return rdy1;
         default: return rdy2;
      endcase
   endfunction

   function automatic int cur_count(input int s);
      case (s)
         0:       return int'(cnt0);
         1:       return int'(cnt1);
         default: return int'(cnt2);
      endcase
   endfunction

   function automatic int nbits(input int s);
      return (s == 2) ? 5 : 8;
   endfunction

   function automatic logic ref_par(input logic [8:0] d, input int nb, input logic odd);
      logic p;
      p = odd;
      for (int i = 0; i < nb; i++) p = p ^ d[i];
      return p;
   endfunction

   // Expected line, one entry per bit period: start, data LSB first, optional parity, stop(s).
   function automatic frame_t make_frame(input int s, input logic [8:0] d, input logic ep);
      frame_t f;
      int     p;
      f.bits    = '1;
      f.bits[0] = 1'b0;
      for (int i = 0; i < nbits(s); i++) f.bits[1+i] = d[i];
      p = 1 + nbits(s);
      if (PB == 1) begin
         f.bits[p] = ep;
         p++;
      end
      f.nper = p + ((s == 1) ? 2 : 1);
      return f;
   endfunction

   // Line monitor: every cycle of every bit period is compared against the popped frame.
   initial begin : monitor
      frame_t f;
      int     bad, start_c;
      bit     aborted;
      forever begin
         @(negedge clk);
         if (rst_nv[mon_sel] && !cur_line(mon_sel)) begin
            start_c = cyc;
            chk("frame_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               f = sb.pop_front();
               if (gap_mode && have_prev) chk("frame_gap", start_c - prev_end, 1);
               aborted = 1'b0;
               for (int p = 0; p < f.nper && !aborted; p++) begin
                  bad = 0;
                  for (int c = 0; c < DIV && !aborted; c++) begin
                     if (p != 0 || c != 0) @(negedge clk);
                     if (!rst_nv[mon_sel]) aborted = 1'b1;
                     else if (cur_line(mon_sel) != f.bits[p]) bad++;
                  end
                  if (!aborted) chk($sformatf("frame_bit%0d_bad_cycles", p), bad, 0);
               end
               if (!aborted) begin
                  prev_end  = cyc;
                  have_prev = 1'b1;
                  frames_ok++;
               end
            end
         end
      end
   end

   task automatic push_word(input int s, input logic [8:0] d, input logic ep);
      int w;
      w = 0;
      @(negedge clk);
      while (!cur_ready(s) && w < 1000) begin
         @(negedge clk);
         w++;
      end
      chk("ready_wait_timeout", int'(w >= 1000), 0);
      sb.push_back(make_frame(s, d, ep));
      drv_dat = d;
      vld[s]  = 1'b1;
      @(negedge clk);
      vld[s]  = 1'b0;
   endtask

   task automatic wait_idle(input int s);
      int w;
      w = 0;
      while ((sb.size() != 0 || cur_busy(s) || !cur_line(s)) && w < 5000) begin
         @(negedge clk);
         w++;
      end
      chk("idle_timeout", int'(w >= 5000), 0);
      repeat (2) @(negedge clk);
   endtask

   // One frame: start-bit latency, busy duration, and a parity_odd flip mid-frame.
   task automatic send_meas(input int s, input logic [8:0] d, input logic odd, input logic ep, input int elen);
      int t, lat, bc;
      bit seen;
      mon_sel = s;
      par_odd = odd;
      push_word(s, d, ep);
      t = 0; lat = -1; bc = 0; seen = 1'b0;
      while (!(seen && !cur_busy(s)) && t < 600) begin
         if (lat < 0 && !cur_line(s)) lat = t;
         if (cur_busy(s)) begin
            bc++;
            seen = 1'b1;
         end
         if (t == 20) par_odd = ~odd;
         @(negedge clk);
         t++;
      end
      chk("start_latency", lat, 2);
      chk("busy_cycles", bc, elen + PB * DIV);
      repeat (2) @(negedge clk);
      chk("count_after_frame", cur_count(s), 0);
   endtask

   typedef struct {
      int         sel;
      logic [8:0] dat;
      logic       odd;
      logic       exp_par;
      int         exp_len;
   } vec_t;

   vec_t       vt[9];
   logic [8:0] bdat[6];
   int         exp_cnt[6];
   int         exp_rdy[6];

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int base, lows, bhi;
      vld     = '0;
      drv_dat = '0;
      par_odd = 1'b0;
      rst_nv  = '1;
      #1 rst_nv = '0;
      #2;
      chk("rst_serial", int'(ser0), 1);
      chk("rst_busy", int'(busy0), 0);
      chk("rst_count", int'(cnt0), 0);
      chk("rst_ready", int'(rdy0), 0);
      chk("rst_count_u2", int'(cnt2), 0);
      @(negedge clk);
      chk("ready_in_reset", int'(rdy0), 0);
      rst_nv = '1;
      @(negedge clk);
      chk("ready_after_release", int'(rdy0), 1);
      chk("ready_after_release_u1", int'(rdy1), 1);

      vt[0] = '{0, 9'h0A5, 1'b0, 1'b0, 100};
      vt[1] = '{0, 9'h007, 1'b0, 1'b1, 100};
      vt[2] = '{0, 9'h007, 1'b1, 1'b0, 100};
      vt[3] = '{0, 9'h0FF, 1'b1, 1'b1, 100};
      vt[4] = '{1, 9'h000, 1'b0, 1'b0, 110};
      vt[5] = '{1, 9'h081, 1'b1, 1'b1, 110};
      vt[6] = '{2, 9'h01F, 1'b0, 1'b1, 70};
      vt[7] = '{2, 9'h00A, 1'b1, 1'b1, 70};
      vt[8] = '{0, 9'h000, 1'b0, 1'b0, 100};
      for (int i = 0; i < 9; i++) begin
         send_meas(vt[i].sel, vt[i].dat, vt[i].odd, vt[i].exp_par, vt[i].exp_len);
      end

      // Two stop bits: the second frame must follow the 20-cycle stop with no gap.
      mon_sel = 1; gap_mode = 1'b1; have_prev = 1'b0; base = frames_ok; par_odd = 1'b0;
      push_word(1, 9'h000, ref_par(9'h000, 8, 1'b0));
      push_word(1, 9'h155, ref_par(9'h155, 8, 1'b0));
      wait_idle(1);
      chk("stop2_frames", frames_ok - base, 2);

      // Six back-to-back offers into a depth-4 queue: five accepted, sent contiguously.
      bdat    = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066};
      exp_cnt = '{1, 1, 2, 3, 4, 4};
      exp_rdy = '{1, 1, 1, 1, 0, 0};
      mon_sel = 0; have_prev = 1'b0; base = frames_ok;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         drv_dat = bdat[i];
         vld[0]  = 1'b1;
         if (i < 5) sb.push_back(make_frame(0, bdat[i], ref_par(bdat[i], 8, 1'b0)));
         @(negedge clk);
         chk($sformatf("burst_count%0d", i), int'(cnt0), exp_cnt[i]);
         chk($sformatf("burst_ready%0d", i), int'(rdy0), exp_rdy[i]);
      end
      vld[0] = 1'b0;
      wait_idle(0);
      chk("burst_frames", frames_ok - base, 5);
      gap_mode = 1'b0;

      // Reset during data bit 3 of 0xA5 (a low bit): line must go high at once.
      push_word(0, 9'h0A5, ref_par(9'h0A5, 8, 1'b0));
      repeat (46) @(negedge clk);
      #2 rst_nv[0] = 1'b0;
      #1;
      chk("midreset_serial", int'(ser0), 1);
      chk("midreset_busy", int'(busy0), 0);
      chk("midreset_count", int'(cnt0), 0);
      chk("midreset_ready", int'(rdy0), 0);
      repeat (3) @(negedge clk);
      rst_nv[0] = 1'b1;
      lows = 0; bhi = 0;
      repeat (30) begin
         @(negedge clk);
         if (!ser0) lows++;
         if (busy0) bhi++;
      end
      chk("post_reset_line_low_cycles", lows, 0);
      chk("post_reset_busy_cycles", bhi, 0);
      send_meas(0, 9'h03C, 1'b0, 1'b0, 100);

      chk("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (5..9).
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (1 or 2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning transmit queue entries (power of two, >=2).
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst_  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port tx_valid  input  1  producer offers tx_data.
REQ-009 SHALL have port tx_data  input  DATA_BITS  frame payload, LSB sent first.
REQ-010 SHALL have port tx_ready  output  1  queue can accept a word.
REQ-011 SHALL have port parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-012 SHALL have port tx_serial  output  1  serial line, idle high.
REQ-013 SHALL have port tx_busy  output  1  high whenever the FSM is not IDLE.
REQ-014 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH+1)  words queued.

Function
REQ-015 SHALL set DIVISOR = CLK_FREQ/BAUD_RATE (integer division); every start, data, parity and stop bit SHALL last exactly DIVISOR clk cycles.
REQ-016 SHALL fail elaboration if DIVISOR<2, DATA_BITS is outside 5..9, STOP_BITS is outside 1..2, or FIFO_DEPTH is not a power of two >=2.
REQ-017 SHALL accept a word on a cycle where tx_valid && tx_ready; tx_ready = (fifo_count < FIFO_DEPTH), registered.
REQ-018 SHALL drop no word and SHALL NOT overwrite queued data; a push while full is ignored, even if a pop occurs in the same cycle.
REQ-019 SHALL run FSM states IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE/START.
REQ-020 IDLE: SHALL pop when the queue is non-empty, load the shifter, latch parity_odd, and enter START; tx_serial SHALL go low on the next edge.
REQ-021 Latency: a push into an empty queue with the FSM idle at edge N SHALL drive tx_serial low at edge N+2.
REQ-022 DATA: SHALL shift out DATA_BITS bits LSB-first, then go to PARITY if enabled, otherwise to STOP.
REQ-023 PARITY: SHALL send XOR(data)^parity_odd, using the latched data and mode.
REQ-024 STOP: SHALL hold the line high for STOP_BITS*DIVISOR cycles.
REQ-025 At the end of STOP, if the queue is non-empty, SHALL pop and go directly to START with no extra idle cycle; otherwise SHALL go to IDLE.
REQ-026 SHALL use a baud counter of width $clog2(DIVISOR); it SHALL reset to 0 at every bit boundary and SHALL never wrap mid-bit.
REQ-027 A push and pop in the same cycle SHALL leave fifo_count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 parity_odd changes mid-frame SHALL NOT affect the frame in flight.

Reset
REQ-029 On rst_ low, SHALL immediately set: state IDLE, tx_serial 1, tx_busy 0, fifo_count 0, tx_ready 0, counters 0, queue empty.
REQ-030 SHALL raise tx_ready on the first edge after rst_ deasserts.
REQ-031 Reset mid-frame SHALL abort the frame; the line SHALL stay high and no partial frame SHALL resume.

Configuration
REQ-032 SHALL use macro UART_TX_PARITY_EN; when defined, the PARITY state and bit SHALL be compiled in.
REQ-033 Without UART_TX_PARITY_EN, SHALL compile no PARITY state, SHALL ignore parity_odd, and frames SHALL be start+data+stop only.

Structure
REQ-034 SHALL place the uart_tx_state_t enum (IDLE, START, DATA, PARITY, STOP) and a parity function in the shared package uart_pkg.
REQ-035 SHALL implement the queue as sub-module uart_tx_fifo (parametrised WIDTH, DEPTH; push/pop/count/full/empty).

Verification (CLK_FREQ=1000, BAUD_RATE=100, DIVISOR=10)
REQ-036 8N1, no parity, push 0xA5 -> line low 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles; tx_busy high 100 cycles.
REQ-037 Parity enabled, push 0x07 with parity_odd=0 -> parity bit 1; repeat with parity_odd=1 -> parity bit 0; frame 110 cycles.
REQ-038 STOP_BITS=2, push 0x00 -> stop high 20 cycles; next pushed frame starts no earlier than cycle 110.
REQ-039 FIFO_DEPTH=4, 6 pushes back-to-back -> 5 accepted (one popped immediately), tx_ready low while count=4; 5 frames sent contiguous with no idle gap.
REQ-040 Assert rst_ during data bit 3 -> tx_serial=1, tx_busy=0, fifo_count=0 without waiting for a clock edge; a push after release sends a clean, full frame.
REQ-041 DATA_BITS=5, push 0x1F -> exactly 5 data-high bit periods, then stop; frame 70 cycles.
